// File: rtl/uart_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   - state_t        : scheduler FSM states (IDLE, LOAD, ARM, WAIT, GAP)
//   - ADDR_W/DATA_W  : launch RAM address / data widths
//   - DEF_*          : default guard gap and watchdog limits
//   - cnt_width()    : width of a down-stream cycle counter able to hold
//                      values 0 .. max(a,b)-1
// -----------------------------------------------------------------------------
package uart_sched_pkg;

   localparam int ADDR_W             = 8;
   localparam int DATA_W             = 8;
   localparam int DEF_GAP_CYCLES     = 2000;
   localparam int DEF_TIMEOUT_CYCLES = 2000000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARM,
      WAIT,
      GAP
   } state_t;

   // One counter is shared by the guard gap and the watchdog, so it is sized
   // for the larger of the two limits.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans the requests starting at the pointer
// (wrapping) and returns the first asserted one. The pointer register itself
// lives in the caller, which loads ptr_next only when it accepts the pick.
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    index with highest priority this cycle
//   any        out  1        at least one request asserted
//   win_idx    out  IDX_W    index of the winner
//   win_onehot out  NUM_REQ  one-hot winner (all zero when any = 0)
//   ptr_next   out  IDX_W    winner + 1 modulo NUM_REQ
// -----------------------------------------------------------------------------
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   win_idx,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0]   ptr_next
);

   int scan_idx;

   always_comb begin
      any        = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      scan_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!any && req[scan_idx]) begin
            any     = 1'b1;
            win_idx = IDX_W'(scan_idx);
         end
      end
      if (any) begin
         win_onehot[win_idx] = 1'b1;
      end
   end

   assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares the UART launch path (launch RAM write port + en_launch) between
// NUM_REQ byte-stream requesters. A round-robin winner is granted, its message
// is copied into launch RAM from address 0, en_launch is raised until the
// launcher's read counter reaches the message length, then a guard gap with
// en_launch low precedes the return to IDLE.
//
// Optional build macro: UART_TX_TIMEOUT_EN adds a WAIT-state watchdog and the
// 'timeout' output port.
//
// Ports:
//   CLK100MHZ              in   1          system clock
//   reset                  in   1          asynchronous active-low reset
//   req_valid              in   NUM_REQ    requester i has a byte
//   req_data               in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//   req_last               in   NUM_REQ    byte is the last of the message
//   req_ready              out  NUM_REQ    byte accepted (granted bit only)
//   grant                  out  NUM_REQ    one-hot launch path owner
//   en_write               out  1          launch RAM write enable
//   launch_write_address   out  8          launch RAM write address
//   launch_write_data      out  8          launch RAM write data
//   en_launch              out  1          launcher enable
//   launch_address_counter in   8          launcher read position (BPS domain)
//   busy                   out  1          state != IDLE
//   done                   out  1          one-cycle pulse, message sent
//   overflow               out  1          sticky, message cut at MAX_LEN
//   timeout                out  1          watchdog pulse (macro only)
// -----------------------------------------------------------------------------
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int MAX_LEN        = 200,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      CLK100MHZ,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      en_write,
   output logic [ADDR_W-1:0]         launch_write_address,
   output logic [DATA_W-1:0]         launch_write_data,
   output logic                      en_launch,
   input  logic [ADDR_W-1:0]         launch_address_counter,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow
`ifdef UART_TX_TIMEOUT_EN
   ,
   output logic                      timeout
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    ptr_reg, g_idx_reg;
   logic [NUM_REQ-1:0]  grant_reg;
   logic [ADDR_W-1:0]   len_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                en_write_reg;
   logic [ADDR_W-1:0]   waddr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                done_reg, overflow_reg;
   logic [ADDR_W-1:0]   sync1_reg, sync2_reg, sync3_reg;

   logic                arb_any;
   logic [IDX_W-1:0]    arb_idx, arb_ptr_next;
   logic [NUM_REQ-1:0]  arb_onehot;

   logic [DATA_W-1:0]   req_byte [NUM_REQ];
   logic                g_valid, g_last, accept;
   logic [DATA_W-1:0]   g_data;
   logic                cnt_stable, len_match, gap_end, at_max;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
         assign req_byte[gi] = req_data[DATA_W*gi +: DATA_W];
      end
   endgenerate

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req        (req_valid),
      .ptr        (ptr_reg),
      .any        (arb_any),
      .win_idx    (arb_idx),
      .win_onehot (arb_onehot),
      .ptr_next   (arb_ptr_next)
   );

   assign g_valid = req_valid[g_idx_reg];
   assign g_last  = req_last[g_idx_reg];
   assign g_data  = req_byte[g_idx_reg];
   assign at_max  = (len_reg == ADDR_W'(MAX_LEN - 1));
   assign gap_end = (cnt_reg == CNT_W'(GAP_CYCLES - 1));

   // The counter comes from the slower BPS domain and may be caught mid-change;
   // a compare is trusted only once two consecutive synchronized samples agree.
   assign cnt_stable = (sync2_reg == sync3_reg);
   assign len_match  = cnt_stable && (sync2_reg == len_reg);

`ifdef UART_TX_TIMEOUT_EN
   logic timeout_reg;
   logic timeout_hit;
   assign timeout_hit = (state_reg == WAIT) && cnt_stable && !len_match &&
                        (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout     = timeout_reg;
`endif

   // State register
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (arb_any) state_next = LOAD;
         LOAD: if (accept && (g_last || at_max)) state_next = ARM;
         ARM:  state_next = WAIT;
         WAIT: begin
            if (len_match) begin
               state_next = GAP;
            end
`ifdef UART_TX_TIMEOUT_EN
            else if (timeout_hit) begin
               state_next = GAP;
            end
`endif
         end
         GAP:  if (gap_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs; req_ready drops as soon as LOAD is left, which is
   // also how a truncated message stops consuming bytes.
   always_comb begin
      req_ready = '0;
      accept    = 1'b0;
      en_launch = (state_reg == WAIT);
      busy      = (state_reg != IDLE);
      if (state_reg == LOAD) begin
         req_ready = grant_reg;
         accept    = g_valid;
      end
   end

   // Datapath, synchronizer and counters
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         ptr_reg      <= '0;
         g_idx_reg    <= '0;
         grant_reg    <= '0;
         len_reg      <= '0;
         cnt_reg      <= '0;
         en_write_reg <= 1'b0;
         waddr_reg    <= '0;
         wdata_reg    <= '0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         sync1_reg    <= '0;
         sync2_reg    <= '0;
         sync3_reg    <= '0;
`ifdef UART_TX_TIMEOUT_EN
         timeout_reg  <= 1'b0;
`endif
      end else begin
         sync1_reg    <= launch_address_counter;
         sync2_reg    <= sync1_reg;
         sync3_reg    <= sync2_reg;
         en_write_reg <= accept;
         done_reg     <= (state_reg == WAIT) && len_match;
`ifdef UART_TX_TIMEOUT_EN
         timeout_reg  <= timeout_hit;
`endif

         if (state_reg == IDLE && arb_any) begin
            grant_reg <= arb_onehot;
            g_idx_reg <= arb_idx;
            ptr_reg   <= arb_ptr_next;
         end

         if (accept) begin
            waddr_reg <= len_reg;
            wdata_reg <= g_data;
            len_reg   <= len_reg + 1'b1;
            if (at_max && !g_last) begin
               overflow_reg <= 1'b1;
            end
         end

         if (state_reg == GAP && gap_end) begin
            grant_reg <= '0;
            len_reg   <= '0;
         end

         // Shared counter: restarts on every state change, counts the gap in
         // GAP and, with the watchdog, counts stable-counter cycles in WAIT.
         if (state_next != state_reg) begin
            cnt_reg <= '0;
         end else if (state_reg == GAP) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
`ifdef UART_TX_TIMEOUT_EN
         else if (state_reg == WAIT) begin
            cnt_reg <= cnt_stable ? cnt_reg + 1'b1 : '0;
         end
`endif
      end
   end

   assign grant                = grant_reg;
   assign en_write             = en_write_reg;
   assign launch_write_address = waddr_reg;
   assign launch_write_data    = wdata_reg;
   assign done                 = done_reg;
   assign overflow             = overflow_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler. A main instance (MAX_LEN=200) covers
// single message, round-robin, synchronizer glitch, mid-load reset and the
// optional watchdog; a second instance with MAX_LEN=4 covers truncation.
// Optional build macro: UART_TX_TIMEOUT_EN (enables test_timeout).
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

   localparam int NR  = 2;
   localparam int GAP = 20;
   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // main instance
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [15:0] req_data;
   logic        en_write, en_launch, busy, done, overflow;
   logic [7:0]  waddr, wdata, lac, lac_man, lac_auto;
   logic        auto_launch;
`ifdef UART_TX_TIMEOUT_EN
   logic        timeout;
`endif

   // truncation instance
   logic [1:0]  o_req_valid, o_req_last, o_req_ready, o_grant;
   logic [15:0] o_req_data;
   logic        o_en_write, o_en_launch, o_busy, o_done, o_overflow;
   logic [7:0]  o_waddr, o_wdata, o_lac;
`ifdef UART_TX_TIMEOUT_EN
   logic        o_timeout;
`endif

   int checks = 0;
   int errors = 0;

   assign lac = auto_launch ? lac_auto : lac_man;

   uart_tx_scheduler #(.NUM_REQ(NR), .MAX_LEN(200), .GAP_CYCLES(GAP),
                       .TIMEOUT_CYCLES(TMO)) dut (
      .CLK100MHZ(clk), .reset(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .grant(grant), .en_write(en_write),
      .launch_write_address(waddr), .launch_write_data(wdata),
      .en_launch(en_launch), .launch_address_counter(lac),
      .busy(busy), .done(done), .overflow(overflow)
`ifdef UART_TX_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   uart_tx_scheduler #(.NUM_REQ(NR), .MAX_LEN(4), .GAP_CYCLES(GAP),
                       .TIMEOUT_CYCLES(TMO)) dut_ovf (
      .CLK100MHZ(clk), .reset(rst_n),
      .req_valid(o_req_valid), .req_data(o_req_data), .req_last(o_req_last),
      .req_ready(o_req_ready), .grant(o_grant), .en_write(o_en_write),
      .launch_write_address(o_waddr), .launch_write_data(o_wdata),
      .en_launch(o_en_launch), .launch_address_counter(o_lac),
      .busy(o_busy), .done(o_done), .overflow(o_overflow)
`ifdef UART_TX_TIMEOUT_EN
      , .timeout(o_timeout)
`endif
   );

   // Write / done monitors (monotonic counters; tests snapshot start values)
   int         wr_total = 0, done_total = 0, to_total = 0, ram_top = 0;
   logic [7:0] wr_addr [0:1023];
   logic [7:0] wr_data [0:1023];
   int         o_wr_total = 0, o_done_total = 0;
   logic [7:0] o_wr_addr [0:63];
   logic [7:0] o_wr_data [0:63];

   always @(negedge clk) begin
      if (en_write === 1'b1) begin
         wr_addr[wr_total % 1024] = waddr;
         wr_data[wr_total % 1024] = wdata;
         wr_total++;
         ram_top = int'(waddr) + 1;
      end
      if (done === 1'b1) done_total++;
`ifdef UART_TX_TIMEOUT_EN
      if (timeout === 1'b1) to_total++;
`endif
      if (o_en_write === 1'b1) begin
         o_wr_addr[o_wr_total % 64] = o_waddr;
         o_wr_data[o_wr_total % 64] = o_wdata;
         o_wr_total++;
      end
      if (o_done === 1'b1) o_done_total++;
   end

   // Launcher model: steps its read position up to the written length while
   // enabled, and parks at 0 when disabled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lac_auto <= 8'd0;
      else if (!en_launch) lac_auto <= 8'd0;
      else if (int'(lac_auto) < ram_top) lac_auto <= lac_auto + 8'd1;
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      auto_launch = 1'b0; lac_man = 8'd0;
      req_valid = '0; req_data = '0; req_last = '0;
      o_req_valid = '0; o_req_data = '0; o_req_last = '0; o_lac = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Sends nmsg messages of nbytes each from requester r, valid held between
   // messages. Byte b of message m is base + 16*m + b.
   task automatic drive_req(input int r, input int nmsg, input int nbytes,
                            input logic [7:0] base);
      logic acc;
      int   n;
      for (int m = 0; m < nmsg; m++) begin
         for (int b = 0; b < nbytes; b++) begin
            req_valid[r]         = 1'b1;
            req_data[8*r +: 8]   = base + 8'(m*16 + b);
            req_last[r]          = (b == nbytes - 1);
            acc = 1'b0; n = 0;
            while (!acc && n < 1000) begin
               @(negedge clk);
               acc = req_ready[r];
               @(posedge clk); #1;
               n++;
            end
            checks++;
            if (!acc) begin
               errors++;
               $display("FAIL drive_req_r%0d: byte %0d ready=0 required 1", r, b);
               req_valid[r] = 1'b0; req_last[r] = 1'b0;
               return;
            end
         end
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic test_reset();
      logic [24:0] obs;
      rst_n = 1'b0;
      auto_launch = 1'b0; lac_man = 8'd0;
      req_valid = '0; req_data = '0; req_last = '0;
      o_req_valid = '0; o_req_data = '0; o_req_last = '0; o_lac = 8'd0;
      #1;
      obs = {req_ready, grant, en_write, waddr, wdata, en_launch, busy, done, overflow};
      checks++;
      if (obs !== 25'd0) begin
         errors++; $display("FAIL reset_outputs: got %h required 0", obs);
      end
      req_valid = 2'b11; req_data = 16'hFFFF; req_last = 2'b11;
      repeat (3) @(negedge clk);
      obs = {req_ready, grant, en_write, waddr, wdata, en_launch, busy, done, overflow};
      checks++;
      if (obs !== 25'd0) begin
         errors++; $display("FAIL reset_held_outputs: got %h required 0", obs);
      end
`ifdef UART_TX_TIMEOUT_EN
      checks++;
      if (timeout !== 1'b0) begin
         errors++; $display("FAIL reset_timeout: got %b required 0", timeout);
      end
`endif
      $display("test_reset: done");
   endtask

   task automatic test_single();
      int w0, d0, n, g, held_bad;
      apply_reset();
      w0 = wr_total; d0 = done_total;
      drive_req(0, 1, 3, 8'h41);
      n = 0;
      while (en_launch !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (en_launch !== 1'b1) begin
         errors++; $display("FAIL single_en_launch: got %b required 1", en_launch);
      end
      checks++;
      if (wr_total - w0 != 3) begin
         errors++; $display("FAIL single_write_count: got %0d required 3", wr_total - w0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({wr_addr[w0+i], wr_data[w0+i]} !== {8'(i), 8'h41 + 8'(i)}) begin
            errors++;
            $display("FAIL single_write%0d: got addr %h data %h required addr %h data %h",
                     i, wr_addr[w0+i], wr_data[w0+i], 8'(i), 8'h41 + 8'(i));
         end
      end
      checks++;
      if (grant !== 2'b01) begin
         errors++; $display("FAIL single_grant: got %b required 01", grant);
      end
      // done appears on the 5th negedge after the counter changes: two
      // synchronizer flops, one stability sample, one output register.
      @(posedge clk); #1 lac_man = 8'd3;
      n = 0;
      while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 5) begin
         errors++; $display("FAIL single_done_latency: got %0d required 5", n);
      end
      checks++;
      if (en_launch !== 1'b0) begin
         errors++; $display("FAIL single_en_launch_low: got %b required 0", en_launch);
      end
      g = 0; held_bad = 0;
      while (busy === 1'b1 && g < GAP + 10) begin
         if (grant !== 2'b01 || en_launch !== 1'b0) held_bad++;
         g++;
         @(negedge clk);
      end
      checks++;
      if (g != GAP || held_bad != 0) begin
         errors++;
         $display("FAIL single_gap: got %0d cycles (%0d bad) required %0d (0 bad)",
                  g, held_bad, GAP);
      end
      checks++;
      if ({grant, done_total - d0, overflow} !== {2'b00, 32'd1, 1'b0}) begin
         errors++;
         $display("FAIL single_end: got grant %b dones %0d ovf %b required 00 1 0",
                  grant, done_total - d0, overflow);
      end
      lac_man = 8'd0;
      $display("test_single: done");
   endtask

   task automatic test_round_robin();
      logic [1:0] order [0:7];
      logic [1:0] prev;
      logic [1:0] exp_order [0:3];
      int ngr, nviol, d0, n;
      logic stop;
      exp_order[0] = 2'b01; exp_order[1] = 2'b10;
      exp_order[2] = 2'b01; exp_order[3] = 2'b10;
      apply_reset();
      auto_launch = 1'b1;
      d0 = done_total; ngr = 0; nviol = 0; prev = 2'b00; stop = 1'b0; n = 0;
      fork
         begin
            while (!stop) begin
               @(negedge clk);
               if ((req_ready & ~grant) !== 2'b00) nviol++;
               if (grant !== 2'b00 && prev === 2'b00 && ngr < 8) begin
                  order[ngr] = grant; ngr++;
               end
               prev = grant;
            end
         end
         begin
            fork
               drive_req(0, 2, 2, 8'h10);
               drive_req(1, 2, 2, 8'h20);
            join
            @(negedge clk);
            while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
            stop = 1'b1;
         end
      join
      checks++;
      if (ngr != 4) begin
         errors++; $display("FAIL rr_grant_count: got %0d required 4", ngr);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i < ngr && order[i] !== exp_order[i]) begin
            errors++; $display("FAIL rr_order%0d: got %b required %b", i, order[i], exp_order[i]);
         end
      end
      checks++;
      if (nviol != 0) begin
         errors++; $display("FAIL rr_ready_nongranted: got %0d cycles required 0", nviol);
      end
      checks++;
      if (done_total - d0 != 4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_done_count: got %0d busy %b required 4 busy 0", done_total - d0, busy);
      end
      auto_launch = 1'b0;
      $display("test_round_robin: done");
   endtask

   task automatic test_glitch();
      int d0, n;
      apply_reset();
      d0 = done_total;
      drive_req(0, 1, 5, 8'h30);
      n = 0;
      while (en_launch !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1 lac_man = 8'd5;
      @(posedge clk); #1 lac_man = 8'd4;
      repeat (8) @(negedge clk);
      checks++;
      if (done_total != d0 || en_launch !== 1'b1) begin
         errors++;
         $display("FAIL glitch_no_done: got dones %0d en_launch %b required 0 1",
                  done_total - d0, en_launch);
      end
      @(posedge clk); #1 lac_man = 8'd5;
      n = 0;
      while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 5) begin
         errors++; $display("FAIL glitch_done_latency: got %0d required 5", n);
      end
      n = 0;
      while (busy === 1'b1 && n < GAP + 10) begin @(negedge clk); n++; end
      checks++;
      if (done_total - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_done_count: got %0d busy %b required 1 busy 0", done_total - d0, busy);
      end
      lac_man = 8'd0;
      $display("test_glitch: done");
   endtask

   task automatic test_overflow();
      int ow0, od0, idx, viol, n;
      logic acc;
      apply_reset();
      ow0 = o_wr_total; od0 = o_done_total; idx = 0; viol = 0;
      o_req_valid = 2'b10; o_req_data = {8'hA0, 8'h00}; o_req_last = 2'b00;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         acc = o_req_ready[1];
         if (o_req_ready[0] !== 1'b0) viol++;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            o_req_data[15:8] = 8'hA0 + 8'(idx);
            if (idx == 6) o_req_valid = 2'b00;
         end
      end
      checks++;
      if (idx != 4 || o_wr_total - ow0 != 4) begin
         errors++;
         $display("FAIL ovf_accepted: got %0d bytes %0d writes required 4 4", idx, o_wr_total - ow0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({o_wr_addr[ow0+i], o_wr_data[ow0+i]} !== {8'(i), 8'hA0 + 8'(i)}) begin
            errors++;
            $display("FAIL ovf_write%0d: got addr %h data %h required addr %h data %h",
                     i, o_wr_addr[ow0+i], o_wr_data[ow0+i], 8'(i), 8'hA0 + 8'(i));
         end
      end
      @(negedge clk);
      checks++;
      if ({o_overflow, o_req_ready, o_en_launch, o_grant} !== {1'b1, 2'b00, 1'b1, 2'b10}
          || viol != 0) begin
         errors++;
         $display("FAIL ovf_state: got ovf %b ready %b en_launch %b grant %b viol %0d required 1 00 1 10 0",
                  o_overflow, o_req_ready, o_en_launch, o_grant, viol);
      end
      o_req_valid = 2'b00;
      @(posedge clk); #1 o_lac = 8'd4;
      n = 0;
      while (o_busy === 1'b1 && n < GAP + 20) begin @(negedge clk); n++; end
      checks++;
      if (o_done_total - od0 != 1 || o_busy !== 1'b0 || o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_complete: got dones %0d busy %b ovf %b required 1 0 1",
                  o_done_total - od0, o_busy, o_overflow);
      end
      o_lac = 8'd0;
      $display("test_overflow: done");
   endtask

   task automatic test_reset_mid_load();
      int w0, w1, n;
      logic [24:0] obs;
      apply_reset();
      w0 = wr_total;
      req_valid[0] = 1'b1; req_data[7:0] = 8'h61; req_last = 2'b00;
      n = 0;
      while (wr_total - w0 < 2 && n < 50) begin @(negedge clk); n++; end
      #2 rst_n = 1'b0;
      #1;
      obs = {req_ready, grant, en_write, waddr, wdata, en_launch, busy, done, overflow};
      checks++;
      if (obs !== 25'd0 || n >= 50) begin
         errors++; $display("FAIL midload_outputs: got %h (waited %0d) required 0", obs, n);
      end
      req_valid = '0; req_data = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      auto_launch = 1'b1;
      w1 = wr_total;
      drive_req(1, 1, 2, 8'h51);
      checks++;
      if (grant !== 2'b10) begin
         errors++; $display("FAIL midload_grant: got %b required 10", grant);
      end
      n = 0;
      while (busy === 1'b1 && n < GAP + 30) begin @(negedge clk); n++; end
      checks++;
      if (wr_total - w1 != 2 ||
          {wr_addr[w1], wr_data[w1], wr_addr[w1+1], wr_data[w1+1]} !== 32'h00_51_01_52) begin
         errors++;
         $display("FAIL midload_reload: got %0d writes %h %h %h %h required 2 00 51 01 52",
                  wr_total - w1, wr_addr[w1], wr_data[w1], wr_addr[w1+1], wr_data[w1+1]);
      end
      auto_launch = 1'b0;
      $display("test_reset_mid_load: done");
   endtask

`ifdef UART_TX_TIMEOUT_EN
   task automatic test_timeout();
      int t0, d0, n;
      apply_reset();
      t0 = to_total; d0 = done_total;
      drive_req(0, 1, 2, 8'h71);
      n = 0;
      while (en_launch !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (timeout !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (n != TMO || en_launch !== 1'b0) begin
         errors++;
         $display("FAIL timeout_cycle: got %0d en_launch %b required %0d 0", n, en_launch, TMO);
      end
      n = 0;
      while (busy === 1'b1 && n < GAP + 10) begin @(negedge clk); n++; end
      checks++;
      if (to_total - t0 != 1 || done_total != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_end: got pulses %0d dones %0d busy %b required 1 0 0",
                  to_total - t0, done_total - d0, busy);
      end
      $display("test_timeout: done");
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_glitch();
      test_overflow();
      test_reset_mid_load();
`ifdef UART_TX_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin arbiter and sequencer sharing the UART launch path (launch RAM write port plus en_launch) between NUM_REQ byte-stream requesters.
- Loads the granted requester's message into launch RAM from address 0, arms en_launch, and waits for the launcher's address counter to reach the message length.
- After a guard gap, returns to idle.
- Sits between on-chip message sources and the UART system top.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- MAX_LEN, 200, max bytes per message (1..255); kept below 256 so the launch RAM is never completely filled
- GAP_CYCLES, 2000, CLK100MHZ cycles en_launch stays low between messages
- TIMEOUT_CYCLES, 2000000, watchdog limit (optional feature only)

Ports:
- CLK100MHZ  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a byte on req_data
- req_data  in  8*NUM_REQ  byte from requester i (bits 8i+7:8i)
- req_last  in  NUM_REQ  byte is the final byte of requester i's message
- req_ready  out  NUM_REQ  byte accepted (only the granted bit may be 1)
- grant  out  NUM_REQ  one-hot owner of the launch path
- en_write  out  1  launch RAM write enable
- launch_write_address  out  8  launch RAM write address
- launch_write_data  out  8  launch RAM write data
- en_launch  out  1  launcher enable
- launch_address_counter  in  8  launcher read position (BPS domain)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a message is fully sent
- overflow  out  1  sticky; message truncated at MAX_LEN; cleared by reset only

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = requester 0.
- launch_address_counter passes through a 2-flop synchronizer. A compare is valid only when two consecutive synchronized samples are equal.
- IDLE:
  - If any req_valid is set, pick the first requester at or after the pointer (wrapping).
  - Set grant on the next cycle and enter LOAD.
  - Pointer = winner+1 mod NUM_REQ.
- LOAD:
  - req_ready[g] = 1. Each cycle with req_valid[g]: en_write=1, address=len, data=req_data[g], then len++.
  - Throughput is 1 byte/cycle; the output is registered with 1-cycle latency from the accepted byte to en_write.
  - Accepting the byte with req_last, or the MAX_LEN-th byte, moves to ARM.
  - Hitting MAX_LEN without last sets overflow and drops req_ready; the remaining requester bytes are not consumed by this block.
- ARM: en_write=0; en_launch rises the next cycle; enter WAIT.
- WAIT:
  - en_launch held 1.
  - When the stable synchronized counter == len: en_launch=0, done pulse, enter GAP.
- GAP:
  - Count GAP_CYCLES with en_launch=0 and grant held.
  - Then clear grant and len, and return to IDLE.
- Minimum message length is 1 byte; no zero-length messages exist (req_last marks a real byte).
- req_valid from non-granted requesters is ignored; their req_ready stays 0.
- A new request arriving during GAP is served immediately on return to IDLE. Arbitration occurs in IDLE only; there is no preemption.
- Asserting reset mid-message aborts immediately:
  - outputs go to 0 asynchronously; the pointer returns to 0.
  - the partial RAM contents are stale and ignored.
- Width rules: len is 8-bit and never exceeds MAX_LEN; launch_write_address = len[7:0].

Optional Feature:
- Macro UART_TX_TIMEOUT_EN.
- Defined:
  - In WAIT, a counter counts cycles since the last change of the synchronized launch_address_counter.
  - When it reaches TIMEOUT_CYCLES: en_launch=0, output timeout pulses 1 cycle, no done pulse, enter GAP.
  - Adds port timeout (out, 1, reset 0).
- Undefined: no timeout port and no watchdog; WAIT lasts indefinitely.

Decomposition:
- Shared package uart_sched_pkg holds:
  - state enum: IDLE, LOAD, ARM, WAIT, GAP
  - ADDR_W=8 and DATA_W=8
  - default GAP_CYCLES and TIMEOUT_CYCLES
- One natural sub-module, rr_arbiter: combinational/pointer round-robin, NUM_REQ-wide, one-hot grant.

Test Plan:
- Single message: requester 0 sends 0x41,0x42,0x43 (last on 0x43).
  - Expect en_write at addresses 0,1,2 with those data, then en_launch=1.
  - Drive counter to 3 → en_launch=0, one done pulse, GAP then IDLE.
- Round-robin: both requesters valid continuously. Expect grant order 0,1,0,1 across four messages, and req_ready never set on the non-granted requester.
- Overflow: with MAX_LEN=4, requester 1 sends 6 bytes without last.
  - Exactly 4 writes (addresses 0-3); overflow=1 and stays set.
  - Launch completes when the counter reaches 4.
- Synchronizer glitch: in WAIT with len=5, the counter shows 5 for one cycle, then 4. Expect no done; done only after 5 holds for 2 samples.
- Reset mid-LOAD: assert reset after 2 bytes. Expect all outputs 0 at once; after release, a requester-1 message is loaded starting at address 0.
- UART_TX_TIMEOUT_EN, TIMEOUT_CYCLES=100: the counter is frozen in WAIT. Expect a timeout pulse at cycle 100, en_launch=0, no done pulse, then IDLE after GAP.
